// File: rtl/alu_input_stage.sv
// Two-phase operand/opcode loader for the 2-bit ALU over a 4-bit bus.
// Define ALU_IN_SWEEP_EN to build the opcode sweep prescaler.
module alu_input_stage #(
  parameter int unsigned PRESCALE_W = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] din,
  input  logic       load,
  input  logic       sweep,
  output logic [1:0] A,
  output logic [1:0] B,
  output logic [3:0] ALU_Sel,
  output logic       valid,
  output logic       phase
);

  typedef enum logic [1:0] {
    S_OPS,
    S_SEL,
    S_RUN
  } state_t;

  state_t     r_state;
  logic       r_ld_s1, r_ld_s2, r_ld_s3;
  logic [3:0] r_din_s1, r_din_s2;
  logic [1:0] r_a, r_b;
  logic [3:0] r_alu_sel;
  logic       r_valid, r_phase;
  logic       w_ld_edge;
  logic       w_tc;

  // Load flops reset high so a strobe held across reset release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_s1  <= 1'b1;
      r_ld_s2  <= 1'b1;
      r_ld_s3  <= 1'b1;
      r_din_s1 <= 4'b0000;
      r_din_s2 <= 4'b0000;
    end else begin
      r_ld_s1  <= load;
      r_ld_s2  <= r_ld_s1;
      r_ld_s3  <= r_ld_s2;
      r_din_s1 <= din;
      r_din_s2 <= r_din_s1;
    end
  end

  assign w_ld_edge = r_ld_s2 & ~r_ld_s3;

`ifdef ALU_IN_SWEEP_EN
  localparam logic [PRESCALE_W-1:0] PRESC_ONE = 1;

  logic                  r_sweep_s1, r_sweep_s2;
  logic [PRESCALE_W-1:0] r_presc;
  logic                  w_presc_run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sweep_s1 <= 1'b0;
      r_sweep_s2 <= 1'b0;
    end else begin
      r_sweep_s1 <= sweep;
      r_sweep_s2 <= r_sweep_s1;
    end
  end

  // A load edge takes priority over terminal count and clears the prescaler.
  assign w_presc_run = (r_state == S_RUN) && r_sweep_s2 && !w_ld_edge;
  assign w_tc        = w_presc_run && (r_presc == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_presc_run && !w_tc) begin
      r_presc <= r_presc + PRESC_ONE;
    end else begin
      r_presc <= '0;
    end
  end
`else
  logic w_unused;

  assign w_tc     = 1'b0;
  assign w_unused = sweep ^ PRESCALE_W[0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_OPS;
      r_a       <= 2'b00;
      r_b       <= 2'b00;
      r_alu_sel <= 4'b0000;
      r_valid   <= 1'b0;
      r_phase   <= 1'b0;
    end else begin
      case (r_state)
        S_OPS: begin
          if (w_ld_edge) begin
            r_a     <= r_din_s2[3:2];
            r_b     <= r_din_s2[1:0];
            r_phase <= 1'b1;
            r_state <= S_SEL;
          end
        end
        S_SEL: begin
          if (w_ld_edge) begin
            r_alu_sel <= r_din_s2;
            r_phase   <= 1'b0;
            r_valid   <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_ld_edge) begin
            r_a     <= r_din_s2[3:2];
            r_b     <= r_din_s2[1:0];
            r_valid <= 1'b0;
            r_phase <= 1'b1;
            r_state <= S_SEL;
          end else if (w_tc) begin
            r_alu_sel <= r_alu_sel + 4'd1;
          end
        end
        default: r_state <= S_OPS;
      endcase
    end
  end

  assign A       = r_a;
  assign B       = r_b;
  assign ALU_Sel = r_alu_sel;
  assign valid   = r_valid;
  assign phase   = r_phase;

endmodule

// File: doc/alu_input_stage.md
# alu_input_stage

Upstream operand-staging stage for the 2-bit ALU. Only six general inputs remain once clock and reset take their pins, and the ALU needs 8 bits of operand and opcode. This block therefore loads A/B and ALU_Sel in two strobed phases over a 4-bit bus. It synchronizes the strobe, holds all ALU inputs stable, and flags when a complete operation is presented. An optional sweep mode steps ALU_Sel through all 16 operations for bring-up.

## Interface
- PRESCALE_W, 10: width of the sweep prescaler; ALU_Sel steps every 2^PRESCALE_W clocks.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- din  in  4  data bus: phase 1 carries {A,B} = din[3:2],din[1:0]; phase 2 carries ALU_Sel.
- load  in  1  asynchronous strobe; each rising edge captures one phase.
- sweep  in  1  level; enables auto-increment of ALU_Sel while an operation is valid.
- A  out  2  operand A to ALU.
- B  out  2  operand B to ALU.
- ALU_Sel  out  4  opcode to ALU.
- valid  out  1  high when A, B and ALU_Sel form a complete loaded operation.
- phase  out  1  high while waiting for the opcode phase.

## Operation
- Input sync: load and din each pass through a 2-flop synchronizer. A third flop on load gives the edge detect: ld_edge = ld_s2 & ~ld_s3.
- Reset values:
  - Load sync flops (ld_s1..ld_s3) reset to 1, so a load held high across reset release produces no capture.
  - The din sync flops reset to 0.
  - All outputs reset to 0, prescaler 0, state S_OPS.
- States:
  - S_OPS: on ld_edge: A<=din_s2[3:2], B<=din_s2[1:0], phase<=1 -> S_SEL.
  - S_SEL: on ld_edge: ALU_Sel<=din_s2, phase<=0, valid<=1, prescaler<=0 -> S_RUN.
  - S_RUN: on ld_edge: capture new A/B, valid<=0, phase<=1 -> S_SEL. ALU_Sel keeps its old value until the new opcode loads.
- In every state, outputs not named above hold their value.
- Sweep, S_RUN only:
  - While sweep_s (sweep through its own 2-flop sync) is high, the prescaler increments each clock.
  - At all-ones, ALU_Sel<=ALU_Sel+1 mod 16 (15 wraps to 0) and the prescaler rolls to 0.
  - sweep_s low or any state other than S_RUN clears the prescaler.
- Simultaneous events: an ld_edge in the same cycle as prescaler terminal count means the load wins. There is no ALU_Sel increment that cycle and the prescaler clears.
- Reset mid-sequence (e.g. in S_SEL) discards the partial load; the next ld_edge is treated as phase 1.
- No arithmetic is performed here; widths pass through unchanged.

## Timing
- load is sampled high at edge k. ld_edge is high during cycle k+1 to k+2. The capture registers at edge k+2, so outputs change 2 clocks after first sampling.
- din must be stable from 1 clock before the load rise until edge k+2.
- Minimum load high and low times are 3 clocks each; shorter pulses may be missed.
- The first sweep step occurs 2^PRESCALE_W clocks after sweep_s rises in S_RUN; later steps follow every 2^PRESCALE_W clocks.
- valid rises in the same edge as the opcode capture and falls in the same edge as a new phase-1 capture.

## Configuration
- ALU_IN_SWEEP_EN defined: sweep synchronizer, prescaler and auto-increment are present as described.
- Not defined:
  - The sweep port remains but is ignored.
  - No prescaler is built.
  - ALU_Sel changes only via the phase-2 load.
  - All other behaviour is identical.

## Test plan
- Reset, then din=4'b1011 with load pulse, then din=4'b1010 with load pulse -> A=2'b10, B=2'b11, ALU_Sel=4'b1010, valid=1, phase=0. Each capture lands 2 clocks after load is sampled.
- Reset asserted in S_SEL after the first load (din=4'b0111) -> all outputs 0, state S_OPS. The next load with din=4'b1101 sets A=2'b11, B=2'b01, phase=1.
- Hold load high through reset release -> no capture, phase=0. A later low-then-high load performs exactly one capture.
- PRESCALE_W=3, macro defined, S_RUN with ALU_Sel=4'b1110, sweep=1 -> ALU_Sel goes to 4'b1111 and then 4'b0000, each step 8 clocks apart.
- Same setup with ld_edge forced onto a terminal-count cycle -> no increment, valid=0, phase=1, A/B updated. Sweep is inactive until the opcode is reloaded.
- Macro undefined, sweep=1 in S_RUN for 5000 clocks -> ALU_Sel unchanged.
